// File: rtl/pool_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pool_pkg                                                                   |
// | Shared FSM state encodings and width helpers for the max-pool stream.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pool_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage
`default_nettype wire

// File: rtl/max_pool_stream_floating_comparator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | floating_comparator                                                        |
// | Combinational binary32 strict a > b; result is a when greater, else b.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module floating_comparator #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  gt,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int EXP_W  = 8;
  localparam int MANT_W = DATA_WIDTH - 1 - EXP_W;

  logic                  w_a_nan;
  logic                  w_b_nan;
  logic                  w_both_zero;
  logic [DATA_WIDTH-2:0] w_a_mag;
  logic [DATA_WIDTH-2:0] w_b_mag;

  assign w_a_mag     = a[DATA_WIDTH-2:0];
  assign w_b_mag     = b[DATA_WIDTH-2:0];
  assign w_a_nan     = (&a[DATA_WIDTH-2:MANT_W]) && (|a[MANT_W-1:0]);
  assign w_b_nan     = (&b[DATA_WIDTH-2:MANT_W]) && (|b[MANT_W-1:0]);
  assign w_both_zero = (w_a_mag == '0) && (w_b_mag == '0);

  // Sign-magnitude ordering; +0/-0 compare equal and NaN is never greater.
  always_comb begin
    gt = 1'b0;
    if (!w_a_nan && !w_b_nan && !w_both_zero) begin
      case ({a[DATA_WIDTH-1], b[DATA_WIDTH-1]})
        2'b00:   gt = (w_a_mag > w_b_mag);
        2'b01:   gt = 1'b1;
        2'b10:   gt = 1'b0;
        default: gt = (w_a_mag < w_b_mag);
      endcase
    end
  end

  assign result = gt ? a : b;

endmodule
`default_nettype wire

// File: rtl/max_pool_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | max_pool_stream                                                            |
// | Streaming non-overlapping 2-D max pooling over a raster binary32 stream.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module max_pool_stream
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int POOL_SIZE  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int SAFE_POOL = (POOL_SIZE < 1) ? 1 : POOL_SIZE;
  localparam int NUM_WIN   = (IMG_WIDTH / SAFE_POOL < 1) ? 1 : IMG_WIDTH / SAFE_POOL;
  localparam int COL_W     = clog2_min1(IMG_WIDTH);
  localparam int ROW_W     = clog2_min1(IMG_HEIGHT);
  localparam int WIN_W     = clog2_min1(NUM_WIN);

  generate
    if (POOL_SIZE < 1) begin : g_bad_pool
      $error("max_pool_stream: POOL_SIZE must be >= 1");
    end else if (((IMG_WIDTH % POOL_SIZE) != 0) || ((IMG_HEIGHT % POOL_SIZE) != 0)) begin : g_bad_dims
      $error("max_pool_stream: IMG_WIDTH and IMG_HEIGHT must be multiples of POOL_SIZE");
    end
  endgenerate

  state_t                r_state;
  logic [COL_W-1:0]      r_col;
  logic [ROW_W-1:0]      r_row;
  logic                  r_in_done;
  logic [DATA_WIDTH-1:0] r_buf [NUM_WIN];
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_out_last;

  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_out_hs;
  logic [31:0]           w_col32;
  logic [31:0]           w_row32;
  logic [31:0]           w_cph;
  logic [31:0]           w_rph;
  logic [WIN_W-1:0]      w_win;
  logic                  w_first;
  logic                  w_last_px;
  logic                  w_col_end;
  logic                  w_row_end;
  logic [DATA_WIDTH-1:0] w_buf_sel;
  logic                  w_cmp_gt;
  logic [DATA_WIDTH-1:0] w_cmp_result;
  logic [DATA_WIDTH-1:0] w_win_max;

  // r_in_done blocks intake between the final pixel and the final output handshake.
  assign w_in_ready = (r_state == ST_RUN) && !r_in_done && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;
  assign w_out_hs   = r_out_valid && out_ready;

  assign w_col32   = 32'(r_col);
  assign w_row32   = 32'(r_row);
  assign w_cph     = w_col32 % SAFE_POOL;
  assign w_rph     = w_row32 % SAFE_POOL;
  assign w_win     = WIN_W'(w_col32 / SAFE_POOL);
  assign w_first   = (w_cph == 32'd0) && (w_rph == 32'd0);
  assign w_last_px = (w_cph == 32'(SAFE_POOL - 1)) && (w_rph == 32'(SAFE_POOL - 1));
  assign w_col_end = (r_col == COL_W'(IMG_WIDTH - 1));
  assign w_row_end = (r_row == ROW_W'(IMG_HEIGHT - 1));
  assign w_buf_sel = r_buf[w_win];

  floating_comparator #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cmp (
    .a      (in_data),
    .b      (w_buf_sel),
    .gt     (w_cmp_gt),
    .result (w_cmp_result)
  );

  // A window's first pixel seeds the running max unconditionally (so a leading NaN sticks).
  assign w_win_max = (w_first || w_cmp_gt) ? in_data : w_cmp_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_in_done   <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_RUN;
            r_col     <= '0;
            r_row     <= '0;
            r_in_done <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_out_hs && r_out_last) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      if (w_accept) begin
        if (w_col_end) begin
          r_col <= '0;
          r_row <= w_row_end ? '0 : r_row + 1'b1;
          if (w_row_end) begin
            r_in_done <= 1'b1;
          end
        end else begin
          r_col <= r_col + 1'b1;
        end
      end

      if (w_accept && w_last_px) begin
        r_out_data  <= w_win_max;
        r_out_valid <= 1'b1;
        r_out_last  <= w_col_end && w_row_end;
      end else if (w_out_hs) begin
        r_out_data  <= '0;
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_accept) begin
      r_buf[w_win] <= w_win_max;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);

endmodule
`default_nettype wire
